// File: rtl/raw_ddr_wr_packer.sv
// raw_ddr_wr_packer: buffers the 16-bit raw pixel stream in a FIFO and issues
// fixed-length DDR write bursts at a linearly advancing, wrapping word address.
// Optional burst statistics counter is enabled by defining WR_PACK_STAT_EN.
module raw_ddr_wr_packer #(
    parameter int FIFO_DEPTH = 64,
    parameter int BURST_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [20:0] ddr_max_addr,
    input  logic        frame_start,
    input  logic        din_en,
    input  logic [15:0] din,
    output logic        burst_req,
    output logic [20:0] burst_addr,
    input  logic        burst_ack,
    input  logic        data_req,
    output logic [15:0] dout,
    output logic        dout_vld,
    output logic        frame_done,
    output logic        overflow
`ifdef WR_PACK_STAT_EN
    ,
    output logic [15:0] burst_cnt
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BLEN_C    = CW'(BURST_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [21:0]   BLEN_A    = 22'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DATA
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  fill_cnt_q, fill_cnt_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic [20:0]    cur_addr_q, cur_addr_d;
    logic           pend_q, pend_d;
    logic           burst_req_q, burst_req_d;
    logic [15:0]    dout_q, dout_d;
    logic           dout_vld_q, dout_vld_d;
    logic           frame_done_q, frame_done_d;
    logic           overflow_q, overflow_d;
`ifdef WR_PACK_STAT_EN
    logic [15:0]    burst_cnt_q, burst_cnt_d;
`endif

    logic [15:0]    mem [FIFO_DEPTH];

    logic           full;
    logic           push;
    logic           pop;
    logic           last_beat;
    logic           start_now;
    logic [21:0]    next_addr;
    logic           wrap;

    assign full      = (fill_cnt_q == DEPTH_C);
    assign push      = din_en & ~full;
    assign pop       = (state_q == S_DATA) & data_req;
    assign last_beat = pop & (beat_q == LAST_BEAT);
    assign start_now = pend_q | frame_start;
    assign next_addr = {1'b0, cur_addr_q} + BLEN_A;
    assign wrap      = (next_addr >= {1'b0, ddr_max_addr});

    // Next-state logic for FIFO bookkeeping, burst FSM and registered outputs
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fill_cnt_d   = fill_cnt_q;
        beat_d       = beat_q;
        cur_addr_d   = cur_addr_q;
        pend_d       = pend_q | frame_start;
        burst_req_d  = burst_req_q;
        dout_d       = dout_q;
        dout_vld_d   = pop;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
`ifdef WR_PACK_STAT_EN
        burst_cnt_d  = burst_cnt_q;
`endif

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            dout_d   = mem[rd_ptr_q];
        end
        unique case ({push, pop})
            2'b10:   fill_cnt_d = fill_cnt_q + CW'(1);
            2'b01:   fill_cnt_d = fill_cnt_q - CW'(1);
            default: fill_cnt_d = fill_cnt_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                // Frame restart only takes effect between bursts
                if (start_now) begin
                    cur_addr_d = '0;
                    pend_d     = 1'b0;
                    overflow_d = 1'b0;
`ifdef WR_PACK_STAT_EN
                    burst_cnt_d = '0;
`endif
                end
                if (fill_cnt_q >= BLEN_C) begin
                    state_d     = S_REQ;
                    burst_req_d = 1'b1;
                end
            end
            S_REQ: begin
                if (burst_ack) begin
                    state_d     = S_DATA;
                    burst_req_d = 1'b0;
                    beat_d      = '0;
                end
            end
            S_DATA: begin
                if (pop) begin
                    beat_d = beat_q + BW'(1);
                end
                if (last_beat) begin
                    state_d      = S_IDLE;
                    cur_addr_d   = wrap ? 21'd0 : next_addr[20:0];
                    frame_done_d = wrap;
`ifdef WR_PACK_STAT_EN
                    burst_cnt_d  = burst_cnt_q + 16'd1;
`endif
                end
            end
            default: begin
                state_d     = S_IDLE;
                burst_req_d = 1'b0;
            end
        endcase

        // A dropped word re-arms the sticky flag even on a restart cycle
        if (din_en && full) begin
            overflow_d = 1'b1;
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            beat_q       <= '0;
            cur_addr_q   <= '0;
            pend_q       <= 1'b0;
            burst_req_q  <= 1'b0;
            dout_q       <= '0;
            dout_vld_q   <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef WR_PACK_STAT_EN
            burst_cnt_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_cnt_q   <= fill_cnt_d;
            beat_q       <= beat_d;
            cur_addr_q   <= cur_addr_d;
            pend_q       <= pend_d;
            burst_req_q  <= burst_req_d;
            dout_q       <= dout_d;
            dout_vld_q   <= dout_vld_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
`ifdef WR_PACK_STAT_EN
            burst_cnt_q  <= burst_cnt_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care after reset since pointers clear
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign burst_req  = burst_req_q;
    assign burst_addr = cur_addr_q;
    assign dout       = dout_q;
    assign dout_vld   = dout_vld_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;
`ifdef WR_PACK_STAT_EN
    assign burst_cnt  = burst_cnt_q;
`endif

endmodule

// File: tb/tb_raw_ddr_wr_packer.sv
// Testbench for raw_ddr_wr_packer: directed stimulus with a scoreboard of
// expected data words and burst addresses checked by a separate monitor.
module tb_raw_ddr_wr_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [20:0] ddr_max_addr = 21'd1024;
    logic        frame_start = 1'b0;
    logic        din_en = 1'b0;
    logic [15:0] din = 16'd0;
    logic        burst_req;
    logic [20:0] burst_addr;
    logic        burst_ack = 1'b0;
    logic        data_req = 1'b0;
    logic [15:0] dout;
    logic        dout_vld;
    logic        frame_done;
    logic        overflow;
`ifdef WR_PACK_STAT_EN
    logic [15:0] burst_cnt;
`endif

    raw_ddr_wr_packer #(
        .FIFO_DEPTH(64),
        .BURST_LEN (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ddr_max_addr(ddr_max_addr),
        .frame_start (frame_start),
        .din_en      (din_en),
        .din         (din),
        .burst_req   (burst_req),
        .burst_addr  (burst_addr),
        .burst_ack   (burst_ack),
        .data_req    (data_req),
        .dout        (dout),
        .dout_vld    (dout_vld),
        .frame_done  (frame_done),
        .overflow    (overflow)
`ifdef WR_PACK_STAT_EN
        ,
        .burst_cnt   (burst_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_data[$];
    logic [20:0] exp_addr[$];
    int vld_cnt = 0;
    int fd_cnt = 0;
    logic req_seen = 1'b0;
    logic [20:0] req_exp = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents output
    always @(negedge clk) begin
        if (rst_n) begin
            if (dout_vld) begin
                vld_cnt++;
                if (exp_data.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL dout_extra: got %0h expected none", dout);
                end else begin
                    chk("dout", 32'(dout), 32'(exp_data.pop_front()));
                end
            end
            if (frame_done) fd_cnt++;
            if (burst_req && !req_seen) begin
                req_seen = 1'b1;
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL burst_extra: got addr %0h expected none",
                             burst_addr);
                end else begin
                    req_exp = exp_addr.pop_front();
                    chk("burst_addr", 32'(burst_addr), 32'(req_exp));
                end
            end else if (burst_req) begin
                chk("addr_stable", 32'(burst_addr), 32'(req_exp));
            end
            if (!burst_req) req_seen = 1'b0;
        end else begin
            req_seen = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w, input bit keep);
        din_en = 1'b1;
        din = w;
        if (keep) exp_data.push_back(w);
        tick();
        din_en = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (!burst_req && n < 300) begin
            tick();
            n++;
        end
        ok = burst_req;
        if (!ok) chk("req_timeout", 32'(burst_req), 32'd1);
    endtask

    task automatic serve(input int dly, input int pulls, input int fs_at);
        bit ok;
        wait_req(ok);
        if (!ok) return;
        repeat (dly) tick();
        burst_ack = 1'b1;
        tick();
        burst_ack = 1'b0;
        chk("req_drop", 32'(burst_req), 32'd0);
        data_req = 1'b1;
        for (int i = 0; i < pulls; i++) begin
            frame_start = (i == fs_at);
            tick();
        end
        frame_start = 1'b0;
        data_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_burst_req"}, 32'(burst_req), 32'd0);
        chk({tag, "_burst_addr"}, 32'(burst_addr), 32'd0);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
        chk({tag, "_dout_vld"}, 32'(dout_vld), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
`ifdef WR_PACK_STAT_EN
        chk({tag, "_burst_cnt"}, 32'(burst_cnt), 32'd0);
`endif
    endtask

    initial begin
        int v0;
        int fd0;
        bit ok;

        #2 rst_n = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        rst_n = 1'b1;
        tick();

        // Basic burst: 16 words, ack 3 cycles after request
        exp_addr.push_back(21'd0);
        for (int i = 0; i < 16; i++) push_word(16'(i), 1'b1);
        chk("req_lat_early", 32'(burst_req), 32'd0);
        tick();
        chk("req_lat", 32'(burst_req), 32'd1);
        serve(3, 16, -1);
        chk("basic_drained", 32'(exp_data.size()), 32'd0);
        chk("basic_next_addr", 32'(burst_addr), 32'd16);

        // Wrap at 48 words
        ddr_max_addr = 21'd48;
        pulse_fs();
        chk("wrap_start_addr", 32'(burst_addr), 32'd0);
        fd0 = fd_cnt;
        exp_addr.push_back(21'd0);
        exp_addr.push_back(21'd16);
        exp_addr.push_back(21'd32);
        exp_addr.push_back(21'd0);
        for (int i = 0; i < 64; i++) push_word(16'h0100 + 16'(i), 1'b1);
        chk("wrap_no_ovf", 32'(overflow), 32'd0);
        serve(0, 16, -1);
        serve(1, 16, -1);
        chk("fd_before_wrap", 32'(fd_cnt - fd0), 32'd0);
        serve(2, 16, -1);
        chk("fd_after_wrap", 32'(fd_cnt - fd0), 32'd1);
        chk("wrap_addr0", 32'(burst_addr), 32'd0);
        serve(0, 16, -1);
        chk("fd_single", 32'(fd_cnt - fd0), 32'd1);
        chk("wrap_next_addr", 32'(burst_addr), 32'd16);

        // Overflow: 70 words with no ack, only 64 survive
        ddr_max_addr = 21'd1024;
        pulse_fs();
        exp_addr.push_back(21'd0);
        exp_addr.push_back(21'd16);
        exp_addr.push_back(21'd32);
        exp_addr.push_back(21'd48);
        for (int i = 0; i < 70; i++) push_word(16'h0200 + 16'(i), i < 64);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_fill", 32'(dut.fill_cnt_q), 32'd64);
        for (int b = 0; b < 4; b++) serve(0, 16, -1);
        chk("ovf_drained", 32'(exp_data.size()), 32'd0);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("ovf_addr", 32'(burst_addr), 32'd64);
        pulse_fs();
        chk("fs_ovf_clr", 32'(overflow), 32'd0);
        chk("fs_addr_clr", 32'(burst_addr), 32'd0);

        // frame_start mid-burst, and over-long data_req
        exp_addr.push_back(21'd0);
        exp_addr.push_back(21'd16);
        exp_addr.push_back(21'd32);
        exp_addr.push_back(21'd0);
        for (int i = 0; i < 48; i++) push_word(16'h0500 + 16'(i), 1'b1);
        serve(0, 16, -1);
        serve(0, 16, -1);
        v0 = vld_cnt;
        serve(1, 20, 5);
        chk("pop_count", 32'(vld_cnt - v0), 32'd16);
        for (int i = 0; i < 16; i++) push_word(16'h0600 + 16'(i), 1'b1);
        serve(0, 16, -1);
        chk("mid_addrs_used", 32'(exp_addr.size()), 32'd0);
        chk("mid_next_addr", 32'(burst_addr), 32'd16);

        // Concurrent traffic: 100 words in while data_req held
        for (int b = 0; b < 6; b++) exp_addr.push_back(21'(16 + 16 * b));
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    din_en = 1'b1;
                    din = 16'h0300 + 16'(i);
                    exp_data.push_back(din);
                    tick();
                end
                din_en = 1'b0;
            end
            begin
                data_req = 1'b1;
                repeat (160) begin
                    burst_ack = burst_req;
                    tick();
                end
                burst_ack = 1'b0;
                data_req = 1'b0;
            end
        join
        tick();
        tick();
        chk("conc_no_ovf", 32'(overflow), 32'd0);
        chk("conc_fill", 32'(dut.fill_cnt_q), 32'd4);
        chk("conc_left", 32'(exp_data.size()), 32'd4);
        chk("conc_addrs_used", 32'(exp_addr.size()), 32'd0);

        // Reset asserted mid-DATA
        exp_addr.push_back(21'd112);
        for (int i = 0; i < 12; i++) push_word(16'h0400 + 16'(i), 1'b1);
        wait_req(ok);
        burst_ack = 1'b1;
        tick();
        burst_ack = 1'b0;
        data_req = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        chk("rst_lost_words", 32'(exp_data.size()), 32'd11);
        exp_data.delete();
        data_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("post_rst_req", 32'(burst_req), 32'd0);
        chk("post_rst_fill", 32'(dut.fill_cnt_q), 32'd0);

`ifdef WR_PACK_STAT_EN
        // Statistics: five bursts then frame restart
        for (int b = 0; b < 5; b++) begin
            exp_addr.push_back(21'(16 * b));
            for (int i = 0; i < 16; i++) push_word(16'h0700 + 16'(16 * b + i), 1'b1);
            serve(0, 16, -1);
        end
        chk("stat_cnt5", 32'(burst_cnt), 32'd5);
        pulse_fs();
        chk("stat_clr", 32'(burst_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
